// File: rtl/ptp_punch_drive_if.sv
// Punch-side handshake and ARM register bus for the paper-tape punch driver.
interface ptp_punch_drive_if;
  logic        punstart;
  logic [7:0]  punchar;
  logic        pundone;
  logic        armwrite;
  logic        armread;
  logic [1:0]  armraddr;
  logic [1:0]  armwaddr;
  logic [31:0] armwdata;
  logic [31:0] armrdata;

  modport master (
    output punstart, punchar, armwrite, armread, armraddr, armwaddr, armwdata,
    input  pundone, armrdata
  );

  modport slave (
    input  punstart, punchar, armwrite, armread, armraddr, armwaddr, armwdata,
    output pundone, armrdata
  );
endinterface

// File: rtl/ptp_punch_drive.sv
// Paper-tape punch driver: queues punched characters for the ARM and paces
// each punch cycle with a microsecond timer before reporting completion.
//
// state   | meaning
// IDLE    | waiting for an enabled punch request
// HOLD    | request pending, FIFO full; waits for the ARM to pop a slot
// PUNCH   | character queued, timing the punch period
// WAITLOW | punch reported done, waiting for punstart to drop
module ptp_punch_drive #(
  parameter int DEPTHLOG2 = 4,
  parameter int TICKDIV   = 100
) (
  input logic CLOCK,
  input logic RESET,
  ptp_punch_drive_if.slave bus
);

  localparam int DEPTH = 1 << DEPTHLOG2;
  localparam int PW    = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
  localparam logic [PW-1:0]        PRE_LAST = PW'(TICKDIV - 1);
  localparam logic [DEPTHLOG2:0]   CNT_FULL = (DEPTHLOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    PUNCH   = 2'd2,
    WAITLOW = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                 enable;
  logic [15:0]          period;
  logic [15:0]          timer;
  logic [PW-1:0]        prescale;
  logic [7:0]           mem [DEPTH];
  logic [DEPTHLOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTHLOG2:0]   count;
  logic [31:0]          count_w;
  logic                 full, empty, push, pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign pop     = bus.armread && (bus.armraddr == 2'd3) && !empty;
  assign count_w = 32'(count);

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // HOLD may use a slot freed by a pop in the same cycle.
  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    bus.pundone = 1'b0;
    case (state)
      IDLE: begin
        if (enable && bus.punstart) begin
          if (!full) begin
            push      = 1'b1;
            state_nxt = PUNCH;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (!full || pop) begin
          push      = 1'b1;
          state_nxt = PUNCH;
        end
      end
      PUNCH: begin
        if (timer == 16'd0) begin
          bus.pundone = 1'b1;
          state_nxt   = WAITLOW;
        end
      end
      WAITLOW: begin
        if (!bus.punstart) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      enable   <= 1'b0;
      period   <= 16'd20000;
      timer    <= 16'd0;
      prescale <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (bus.armwrite && (bus.armwaddr == 2'd1)) begin
        enable <= bus.armwdata[31];
        period <= bus.armwdata[15:0];
      end
      // The running timer is loaded only on push, so period writes take effect next character.
      if (push) begin
        timer    <= period;
        prescale <= '0;
      end else if ((state == PUNCH) && (timer != 16'd0)) begin
        if (prescale == PRE_LAST) begin
          prescale <= '0;
          timer    <= timer - 16'd1;
        end else begin
          prescale <= prescale + 1'b1;
        end
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET && push) mem[wr_ptr] <= bus.punchar;
  end

  always_comb begin
    bus.armrdata = 32'd0;
    case (bus.armraddr)
      2'd0: bus.armrdata = 32'h5044_1001;
      2'd1: bus.armrdata = {enable, 15'd0, period};
      2'd2: bus.armrdata = {full, empty, 2'b00, state, 21'd0, count_w[4:0]};
      2'd3: bus.armrdata = empty ? 32'd0 : {1'b1, 23'd0, mem[rd_ptr]};
      default: bus.armrdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_ptp_punch_drive.sv
// Scoreboard bench for the punch driver: a queue-based model predicts register
// reads and pundone cycles; a monitor checks them as the DUT presents them.
module tb_ptp_punch_drive;
  localparam int TD = 4;

  logic CLOCK;
  logic RESET;
  ptp_punch_drive_if bus ();

  ptp_punch_drive #(.DEPTHLOG2(4), .TICKDIV(TD)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  logic [31:0] exp_rd[$];
  int          exp_done[$];
  logic [7:0]  mq[$];
  bit          m_en;
  int          m_per;

  logic [31:0] mon_e;
  int          mon_c;
  always @(negedge CLOCK) begin
    if (bus.armread) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected addr=%0d got %h", bus.armraddr, bus.armrdata);
      end else begin
        mon_e = exp_rd.pop_front();
        if (bus.armrdata !== mon_e) begin
          errors++;
          $display("FAIL rd addr=%0d cyc=%0d got %h exp %h", bus.armraddr, cyc, bus.armrdata, mon_e);
        end
      end
    end
    if (bus.pundone) begin
      checks++;
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL pundone_unexpected cyc=%0d", cyc);
      end else begin
        mon_c = exp_done.pop_front();
        if (cyc != mon_c) begin
          errors++;
          $display("FAIL pundone_time got cyc %0d exp cyc %0d", cyc, mon_c);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d exp 0 pending", cyc);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.armwrite = 1'b1;
    bus.armwaddr = a;
    bus.armwdata = d;
    tick();
    bus.armwrite = 1'b0;
    if (a == 2'd1) begin
      m_en  = d[31];
      m_per = int'(d[15:0]);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    bus.armread  = 1'b1;
    bus.armraddr = a;
    exp_rd.push_back(e);
    tick();
    bus.armread = 1'b0;
  endtask

  function automatic logic [31:0] reg2(input logic [1:0] st);
    int n;
    n = mq.size();
    return {n == 16, n == 0, 2'b00, st, 21'd0, 5'(n)};
  endfunction

  task automatic rd_head();
    logic [31:0] e;
    if (mq.size() > 0) e = {1'b1, 23'd0, mq.pop_front()};
    else               e = 32'd0;
    rd(2'd3, e);
  endtask

  // One complete punch cycle: request, wait for done, release.
  task automatic punch(input logic [7:0] ch);
    int due;
    bus.punstart = 1'b1;
    bus.punchar  = ch;
    due = cyc + 1 + m_per * TD;
    mq.push_back(ch);
    exp_done.push_back(due);
    while (cyc < due + 1) tick();
    bus.punstart = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int due;
    logic [7:0] x;
    bus.punstart = 1'b0;
    bus.punchar  = 8'd0;
    bus.armwrite = 1'b0;
    bus.armread  = 1'b0;
    bus.armraddr = 2'd0;
    bus.armwaddr = 2'd0;
    bus.armwdata = 32'd0;
    RESET = 1'b1;
    m_en  = 1'b0;
    m_per = 20000;
    repeat (3) tick();
    RESET = 1'b0;

    // reset state
    rd(2'd0, 32'h5044_1001);
    rd(2'd1, 32'h0000_4E20);
    rd(2'd2, reg2(2'd0));
    rd_head();
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'h5044_1001);

    // single character, period 2
    wr(2'd1, 32'h8000_0002);
    rd(2'd1, 32'h8000_0002);
    bus.punstart = 1'b1;
    bus.punchar  = 8'h41;
    due = cyc + 1 + 2 * TD;
    mq.push_back(8'h41);
    exp_done.push_back(due);
    tick();
    rd(2'd2, reg2(2'd2));
    while (cyc < due + 1) tick();
    rd(2'd2, reg2(2'd3));
    rd(2'd2, reg2(2'd3));
    bus.punstart = 1'b0;
    tick();
    rd(2'd2, reg2(2'd0));
    rd_head();
    rd_head();
    rd(2'd2, reg2(2'd0));

    // period 0, then disabled
    wr(2'd1, 32'h8000_0000);
    punch(8'($urandom));
    rd_head();
    wr(2'd1, 32'h0000_0003);
    bus.punstart = 1'b1;
    repeat (5) tick();
    rd(2'd2, reg2(2'd0));
    bus.punstart = 1'b0;
    tick();

    // fill the FIFO, 17th request holds until a pop
    wr(2'd1, 32'h8000_0000);
    for (int i = 0; i < 16; i++) punch(8'(i));
    rd(2'd2, reg2(2'd0));
    x = 8'($urandom);
    bus.punstart = 1'b1;
    bus.punchar  = x;
    repeat (3) tick();
    rd(2'd2, reg2(2'd1));
    due = cyc + 1;
    exp_done.push_back(due);
    rd_head();
    mq.push_back(x);
    rd(2'd2, reg2(2'd2));
    tick();
    bus.punstart = 1'b0;
    tick();
    tick();

    // drain in order
    while (mq.size() > 0) rd_head();
    rd_head();
    rd(2'd2, reg2(2'd0));

    // push and pop together at count 5; period write during PUNCH
    for (int i = 0; i < 5; i++) punch(8'($urandom));
    wr(2'd1, 32'h8000_0001);
    x = 8'($urandom);
    bus.punstart = 1'b1;
    bus.punchar  = x;
    due = cyc + 1 + TD;
    exp_done.push_back(due);
    rd_head();
    mq.push_back(x);
    rd(2'd2, reg2(2'd2));
    wr(2'd1, 32'h8000_0003);
    while (cyc < due + 1) tick();
    bus.punstart = 1'b0;
    tick();
    tick();
    punch(8'($urandom));
    rd(2'd2, reg2(2'd0));

    // randomized mix
    repeat (30) begin
      case ($urandom_range(0, 3))
        0: wr(2'd1, {1'b1, 15'd0, 16'($urandom_range(0, 3))});
        1, 2: if (m_en && mq.size() < 16) punch(8'($urandom));
        default: rd_head();
      endcase
      rd(2'd2, reg2(2'd0));
    end

    // reset in the middle of a punch
    wr(2'd1, 32'h8000_0003);
    bus.punstart = 1'b1;
    bus.punchar  = 8'($urandom);
    repeat (6) tick();
    RESET = 1'b1;
    bus.punstart = 1'b0;
    bus.armwrite = 1'b1;
    bus.armwaddr = 2'd1;
    bus.armwdata = 32'h8000_0001;
    tick();
    RESET = 1'b0;
    bus.armwrite = 1'b0;
    mq.delete();
    m_en  = 1'b0;
    m_per = 20000;
    rd(2'd1, 32'h0000_4E20);
    rd(2'd2, reg2(2'd0));
    rd_head();
    repeat (30) tick();

    checks++;
    if (exp_done.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL pending got done=%0d rd=%0d exp 0 0", exp_done.size(), exp_rd.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
